vin_timing_monitor: RTL and testbench

//  Watches the registered HDMI-in timing (hs/vs/de) in the vin_clk_i domain, just after
//  the input capture registers and ahead of the gray/blk/lin/frm buffers. Measures

---
 rtl/vin_timing_monitor.sv | 183 ++++++++++++++++++
 tb/tb_vin_timing_monitor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vin_timing_monitor.sv
// Checks registered HDMI-in hs/vs/de against the build-time timing once per frame and
// reports lock status, per-frame pulses and the last measured width/height/htotal.
module vin_timing_monitor #(
    parameter int unsigned H_WIDTH     = 1920,
    parameter int unsigned H_TOTAL     = 2200,
    parameter int unsigned V_HEIGHT    = 1080,
    parameter int unsigned LOCK_FRAMES = 4,
    parameter int unsigned CW          = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          hs_i,
    input  logic          vs_i,
    input  logic          de_i,
    output logic          locked_o,
    output logic          frame_o,
    output logic          err_o,
    output logic [CW-1:0] width_o,
    output logic [CW-1:0] height_o,
    output logic [CW-1:0] htotal_o
);

    localparam int unsigned WW = CW + 12;
    localparam int unsigned GW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;
    localparam logic [CW-1:0] CntMax   = '1;
    localparam logic [CW-1:0] HWidth   = CW'(H_WIDTH);
    localparam logic [CW-1:0] HTotal   = CW'(H_TOTAL);
    localparam logic [CW-1:0] VHeight  = CW'(V_HEIGHT);
    localparam logic [GW-1:0] GoodLock = GW'(LOCK_FRAMES);
    localparam logic [WW-1:0] WdLimit  = WW'(H_TOTAL) << CW;

    typedef enum logic [1:0] {StSeek, StCheck, StLocked} state_e;

    state_e        state_q, state_d;
    logic          hs_q, vs_q, de_q;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [CW-1:0] hs_cnt_q, hs_cnt_d;
    logic [CW-1:0] line_cnt_q, line_cnt_d;
    logic [CW-1:0] last_width_q, last_width_d;
    logic [CW-1:0] last_period_q, last_period_d;
    logic          hs_seen_q, hs_seen_d;
    logic          bad_q, bad_d;
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic          frame_q, frame_d, err_q, err_d;
    logic [CW-1:0] width_q, width_d, height_q, height_d, htotal_q, htotal_d;

    logic          fb, line_end, hs_rise, wd_fire, cyc_bad, frame_bad;
    logic [CW-1:0] period, line_total;

    assign fb       = vs_i & ~vs_q;
    assign line_end = de_q & ~de_i;
    assign hs_rise  = hs_i & ~hs_q;
    assign period   = (hs_cnt_q == CntMax) ? CntMax : hs_cnt_q + 1'b1;
    assign wd_fire  = !fb && (wd_cnt_q == WdLimit - 1'b1);

    // Events in the FB cycle itself are attributed to the frame being closed.
    always_comb begin
        line_total = line_cnt_q;
        if (line_end && line_cnt_q != CntMax) begin
            line_total = line_cnt_q + 1'b1;
        end
        line_cnt_d = fb ? '0 : line_total;

        pix_cnt_d = pix_cnt_q;
        if (line_end) begin
            pix_cnt_d = '0;
        end else if (de_i && pix_cnt_q != CntMax) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end

        hs_cnt_d = hs_cnt_q;
        if (hs_rise) begin
            hs_cnt_d = '0;
        end else if (hs_cnt_q != CntMax) begin
            hs_cnt_d = hs_cnt_q + 1'b1;
        end

        last_width_d  = line_end ? pix_cnt_q : last_width_q;
        last_period_d = hs_rise ? period : last_period_q;
        hs_seen_d     = fb ? 1'b0 : (hs_seen_q | hs_rise);

        cyc_bad = (line_end && pix_cnt_q != HWidth)
                | (hs_rise && hs_seen_q && period != HTotal)
                | (de_i && vs_i)
                | (pix_cnt_q == CntMax) | (hs_cnt_q == CntMax) | (line_cnt_q == CntMax);
        frame_bad = bad_q | cyc_bad | (line_total != VHeight);
        bad_d     = fb ? 1'b0 : (bad_q | cyc_bad);

        wd_cnt_d = wd_cnt_q;
        if (fb) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WdLimit) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        frame_d  = 1'b0;
        err_d    = 1'b0;
        width_d  = width_q;
        height_d = height_q;
        htotal_d = htotal_q;
        if (fb) begin
            if (state_q == StSeek) begin
                // Partial frame after reset: resync only, nothing reported.
                state_d = StCheck;
                good_d  = '0;
            end else begin
                frame_d  = 1'b1;
                width_d  = last_width_d;
                height_d = line_total;
                htotal_d = last_period_d;
                if (frame_bad) begin
                    state_d = StCheck;
                    good_d  = '0;
                    err_d   = 1'b1;
                end else if (state_q == StCheck) begin
                    good_d = good_q + 1'b1;
                    if (good_q + 1'b1 == GoodLock) begin
                        state_d = StLocked;
                    end
                end
            end
        end else if (wd_fire) begin
            state_d = StCheck;
            good_d  = '0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StSeek;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            pix_cnt_q     <= '0;
            hs_cnt_q      <= '0;
            line_cnt_q    <= '0;
            last_width_q  <= '0;
            last_period_q <= '0;
            hs_seen_q     <= 1'b0;
            bad_q         <= 1'b0;
            wd_cnt_q      <= '0;
            good_q        <= '0;
            frame_q       <= 1'b0;
            err_q         <= 1'b0;
            width_q       <= '0;
            height_q      <= '0;
            htotal_q      <= '0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_i;
            vs_q          <= vs_i;
            de_q          <= de_i;
            pix_cnt_q     <= pix_cnt_d;
            hs_cnt_q      <= hs_cnt_d;
            line_cnt_q    <= line_cnt_d;
            last_width_q  <= last_width_d;
            last_period_q <= last_period_d;
            hs_seen_q     <= hs_seen_d;
            bad_q         <= bad_d;
            wd_cnt_q      <= wd_cnt_d;
            good_q        <= good_d;
            frame_q       <= frame_d;
            err_q         <= err_d;
            width_q       <= width_d;
            height_q      <= height_d;
            htotal_q      <= htotal_d;
        end
    end

    assign locked_o = (state_q == StLocked);
    assign frame_o  = frame_q;
    assign err_o    = err_q;
    assign width_o  = width_q;
    assign height_o = height_q;
    assign htotal_o = htotal_q;

endmodule

// File: tb/tb_vin_timing_monitor.sv
// Directed bench for vin_timing_monitor with a shrunken 8/12/4 timing so frames are short.
module tb_vin_timing_monitor;

    localparam int unsigned HW = 8;
    localparam int unsigned HT = 12;
    localparam int unsigned VH = 4;
    localparam int unsigned LF = 4;
    localparam int unsigned CW = 6;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          hs_i = 1'b0, vs_i = 1'b0, de_i = 1'b0;
    logic          locked_o, frame_o, err_o;
    logic [CW-1:0] width_o, height_o, htotal_o;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_cnt = 0;
    int err_cnt   = 0;
    int f0, e0;

    vin_timing_monitor #(
        .H_WIDTH    (HW),
        .H_TOTAL    (HT),
        .V_HEIGHT   (VH),
        .LOCK_FRAMES(LF),
        .CW         (CW)
    ) u_dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .hs_i    (hs_i),
        .vs_i    (vs_i),
        .de_i    (de_i),
        .locked_o(locked_o),
        .frame_o (frame_o),
        .err_o   (err_o),
        .width_o (width_o),
        .height_o(height_o),
        .htotal_o(htotal_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (frame_o) frame_cnt++;
            if (err_o) err_cnt++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic gen_line(input bit vs, input bit act, input int wid, input int tot);
        for (int c = 0; c < tot; c++) begin
            @(negedge clk_i);
            hs_i = (c < 2);
            vs_i = vs;
            de_i = act && (c >= 3) && (c < 3 + wid);
        end
    endtask

    // Two vsync lines then n_act active lines; vs rises on the first cycle.
    task automatic gen_frame(input int n_act, input int bad_line, input int bad_wid,
                             input int long_line);
        gen_line(1'b1, 1'b0, 0, HT);
        gen_line(1'b1, 1'b0, 0, HT);
        for (int a = 0; a < n_act; a++) begin
            gen_line(1'b0, 1'b1, (a == bad_line) ? bad_wid : HW,
                     (a == long_line) ? HT + 1 : HT);
        end
    endtask

    task automatic good_frames(input int n);
        for (int i = 0; i < n; i++) gen_frame(VH, -1, 0, -1);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_locked", locked_o, 0);
        check("rst_frame", frame_o, 0);
        check("rst_err", err_o, 0);
        check("rst_width", width_o, 0);
        check("rst_height", height_o, 0);
        check("rst_htotal", htotal_o, 0);
        rst_i = 1'b0;

        // 1: first FB only resyncs; four good frames lock at the fifth FB
        good_frames(1);
        check("t1_seek_no_frame", frame_cnt, 0);
        good_frames(3);
        check("t1_not_locked_fb4", locked_o, 0);
        good_frames(1);
        check("t1_locked_fb5", locked_o, 1);
        good_frames(1);
        check("t1_frames", frame_cnt, 5);
        check("t1_errs", err_cnt, 0);
        check("t1_width", width_o, HW);
        check("t1_height", height_o, VH);
        check("t1_htotal", htotal_o, HT);

        // 2: last line one pixel short
        f0 = frame_cnt; e0 = err_cnt;
        gen_frame(VH, VH - 1, HW - 1, -1);
        check("t2_locked_before_fb", locked_o, 1);
        good_frames(1);
        check("t2_err", err_cnt - e0, 1);
        check("t2_unlocked", locked_o, 0);
        check("t2_width", width_o, HW - 1);
        good_frames(3);
        check("t2_not_relocked", locked_o, 0);
        good_frames(1);
        check("t2_relocked", locked_o, 1);
        check("t2_frames", frame_cnt - f0, 6);

        // 3: one line missing, then 4: one long hs period mid-frame
        e0 = err_cnt;
        gen_frame(VH - 1, -1, 0, -1);
        gen_frame(VH, -1, 0, 1);
        check("t3_err", err_cnt - e0, 1);
        check("t3_height", height_o, VH - 1);
        check("t3_unlocked", locked_o, 0);
        good_frames(1);
        check("t4_err", err_cnt - e0, 2);
        check("t4_htotal", htotal_o, HT);
        check("t4_height", height_o, VH);
        good_frames(4);
        check("t4_relocked", locked_o, 1);

        // 5: vsync stops; watchdog at 2**CW*H_TOTAL = 768 cycles
        f0 = frame_cnt; e0 = err_cnt;
        for (int i = 0; i < 50; i++) gen_line(1'b0, 1'b0, 0, HT);
        check("t5_locked_pre_wd", locked_o, 1);
        check("t5_no_err_pre_wd", err_cnt - e0, 0);
        for (int i = 0; i < 14; i++) gen_line(1'b0, 1'b0, 0, HT);
        check("t5_unlocked", locked_o, 0);
        check("t5_one_err", err_cnt - e0, 1);
        check("t5_no_frame", frame_cnt - f0, 0);
        good_frames(5);
        check("t5_relocked", locked_o, 1);

        // 6: asynchronous reset mid-frame
        gen_line(1'b1, 1'b0, 0, HT);
        gen_line(1'b1, 1'b0, 0, HT);
        gen_line(1'b0, 1'b1, HW, HT);
        @(negedge clk_i);
        rst_i = 1'b1;
        hs_i = 1'b0; vs_i = 1'b0; de_i = 1'b0;
        #1;
        check("t6_locked", locked_o, 0);
        check("t6_frame", frame_o, 0);
        check("t6_err", err_o, 0);
        check("t6_width", width_o, 0);
        check("t6_height", height_o, 0);
        check("t6_htotal", htotal_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        f0 = frame_cnt; e0 = err_cnt;
        good_frames(1);
        check("t6_seek_no_frame", frame_cnt - f0, 0);
        good_frames(1);
        check("t6_frame_after", frame_cnt - f0, 1);
        check("t6_no_err", err_cnt - e0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
